// File: rtl/pwm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_pkg : shared widths, FSM encoding and duty rounding reference  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pwm_pkg;

  localparam int DUTY_W         = 4;
  localparam int DUTY_STEPS_DEF = 10;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } meter_state_e;

  function automatic logic [DUTY_W-1:0] duty_round_ref(input int unsigned hi,
                                                       input int unsigned per);
    int unsigned q;
    if (per == 0) return '0;
    q = (int'(DUTY_STEPS_DEF) * hi + per / 2) / per;
    if (q > int'(DUTY_STEPS_DEF)) q = DUTY_STEPS_DEF;
    return q[DUTY_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_duty_div.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_duty_div : rounding divider, q = min(STEPS, (STEPS*hi+per/2)/per)|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DUTY_STEPS = DUTY_STEPS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  hi_i,
  input  logic [CNT_W-1:0]  per_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DUTY_W-1:0] q_o
);

  localparam int                ACC_W   = CNT_W + 4;
  localparam logic [DUTY_W-1:0] STEPS_C = DUTY_W'(DUTY_STEPS);
  localparam logic [ACC_W-1:0]  MULT_C  = ACC_W'(DUTY_STEPS);

  logic              busy_q, busy_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  per_q, per_d;
  logic [DUTY_W-1:0] q_q, q_d;
  logic              stop;

  // The quotient cap doubles as the clamp, so the loop never exceeds STEPS iterations.
  assign stop = (acc_q < ACC_W'(per_q)) || (q_q == STEPS_C);

  always_comb begin
    busy_d = busy_q;
    acc_d  = acc_q;
    per_d  = per_q;
    q_d    = q_q;
    if (!busy_q) begin
      if (start_i) begin
        busy_d = 1'b1;
        acc_d  = ACC_W'(hi_i) * MULT_C + ACC_W'(per_i >> 1);
        per_d  = per_i;
        q_d    = '0;
      end
    end else if (stop) begin
      busy_d = 1'b0;
    end else begin
      acc_d = acc_q - ACC_W'(per_q);
      q_d   = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      acc_q  <= '0;
      per_q  <= '0;
      q_q    <= '0;
    end else begin
      busy_q <= busy_d;
      acc_q  <= acc_d;
      per_q  <= per_d;
      q_q    <= q_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q & stop;
  assign q_o    = q_q;

endmodule
`default_nettype wire

// File: rtl/pwm_duty_meter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_duty_meter : measures PWM high time/period, rounds to duty step |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pwm_duty_meter
  import pwm_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TIMEOUT    = 1000,
  parameter int DUTY_STEPS = DUTY_STEPS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic              meas_valid,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [DUTY_W-1:0] duty_step,
  output logic              stuck,
  output logic              stuck_level,
  output logic              busy
);

  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [DUTY_W-1:0] STEPS_C   = DUTY_W'(DUTY_STEPS);

  logic              sync1_q, sync2_q, sync_prev_q;
  logic              rise, capture, tout_take;
  logic [CNT_W-1:0]  per_q, per_d, hi_q, hi_d;
  logic [CNT_W-1:0]  cap_hi_q, cap_per_q;
  logic              armed_q, armed_d;
  meter_state_e      state_q, state_d;
  logic              div_busy, div_done;
  logic [DUTY_W-1:0] div_q;

  logic              meas_valid_q, meas_valid_d;
  logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              stuck_q, stuck_d;
  logic              stuck_level_q, stuck_level_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync_prev_q <= 1'b0;
    end else begin
      sync1_q     <= pwm_in;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
    end
  end

  assign rise    = sync2_q & ~sync_prev_q;
  assign capture = rise & armed_q & (state_q == IDLE);
  // A saturated period counter keeps the timeout pending while CALC/DONE finish.
  assign tout_take = (per_q == TIMEOUT_C) & ~stuck_q & ~rise & (state_q == IDLE);

  always_comb begin
    per_d   = per_q;
    hi_d    = hi_q;
    armed_d = armed_q;
    if (rise) begin
      per_d   = CNT_W'(1);
      hi_d    = CNT_W'(1);
      armed_d = 1'b1;
    end else begin
      if (per_q < TIMEOUT_C) per_d = per_q + 1'b1;
      if (sync2_q && (hi_q < TIMEOUT_C)) hi_d = hi_q + 1'b1;
      if (tout_take) armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      per_q     <= '0;
      hi_q      <= '0;
      armed_q   <= 1'b0;
      cap_hi_q  <= '0;
      cap_per_q <= '0;
    end else begin
      per_q   <= per_d;
      hi_q    <= hi_d;
      armed_q <= armed_d;
      if (capture) begin
        cap_hi_q  <= hi_q;
        cap_per_q <= per_q;
      end
    end
  end

  pwm_duty_div #(
    .CNT_W      (CNT_W),
    .DUTY_STEPS (DUTY_STEPS)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (capture),
    .hi_i    (hi_q),
    .per_i   (per_q),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .q_o     (div_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture)  state_d = CALC;
      CALC:    if (div_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result registers load on the edge entering DONE, so they present during DONE.
  always_comb begin
    meas_valid_d  = 1'b0;
    high_cnt_d    = high_cnt_q;
    period_cnt_d  = period_cnt_q;
    duty_d        = duty_q;
    stuck_d       = stuck_q;
    stuck_level_d = stuck_level_q;
    if (rise) stuck_d = 1'b0;
    if ((state_q == CALC) && div_done) begin
      meas_valid_d = 1'b1;
      high_cnt_d   = cap_hi_q;
      period_cnt_d = cap_per_q;
      duty_d       = div_q;
      stuck_d      = 1'b0;
    end
    if (tout_take) begin
      meas_valid_d  = 1'b1;
      high_cnt_d    = '0;
      period_cnt_d  = '0;
      duty_d        = sync2_q ? STEPS_C : '0;
      stuck_d       = 1'b1;
      stuck_level_d = sync2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meas_valid_q  <= 1'b0;
      high_cnt_q    <= '0;
      period_cnt_q  <= '0;
      duty_q        <= '0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      meas_valid_q  <= meas_valid_d;
      high_cnt_q    <= high_cnt_d;
      period_cnt_q  <= period_cnt_d;
      duty_q        <= duty_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
    end
  end

  assign meas_valid  = meas_valid_q;
  assign high_cnt    = high_cnt_q;
  assign period_cnt  = period_cnt_q;
  assign duty_step   = duty_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_level_q;
  assign busy        = div_busy;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_meter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pwm_duty_meter : scoreboard bench for pwm_duty_meter            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pwm_duty_meter;

  localparam int TIMEOUT = 1000;

  typedef struct {
    logic [15:0] hi;
    logic [15:0] per;
    logic [3:0]  duty;
    logic        stuck;
    logic        lvl;
    bit          chk_lvl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pwm_in;
  logic        meas_valid;
  logic [15:0] high_cnt;
  logic [15:0] period_cnt;
  logic [3:0]  duty_step;
  logic        stuck;
  logic        stuck_level;
  logic        busy;

  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   pulse_cnt = 0;
  int   last_pulse_cyc = 0;
  int   last_rise_cyc  = 0;
  int   push_cnt  = 0;
  bit   tb_armed  = 0;
  bit   push_en   = 1;
  int   prev_h    = 0;
  int   prev_p    = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  pwm_duty_meter #(
    .CNT_W      (16),
    .TIMEOUT    (TIMEOUT),
    .DUTY_STEPS (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .meas_valid  (meas_valid),
    .high_cnt    (high_cnt),
    .period_cnt  (period_cnt),
    .duty_step   (duty_step),
    .stuck       (stuck),
    .stuck_level (stuck_level),
    .busy        (busy)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (meas_valid === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_meas_valid: got hi=%0d per=%0d duty=%0d stuck=%0b, required no pulse",
                 high_cnt, period_cnt, duty_step, stuck);
      end else begin
        mon_e = sb.pop_front();
        if ({high_cnt, period_cnt, duty_step, stuck} !== {mon_e.hi, mon_e.per, mon_e.duty, mon_e.stuck} ||
            (mon_e.chk_lvl && (stuck_level !== mon_e.lvl))) begin
          failures++;
          $display("FAIL meas_record: got hi=%0d per=%0d duty=%0d stuck=%0b lvl=%0b, required hi=%0d per=%0d duty=%0d stuck=%0b lvl=%0b",
                   high_cnt, period_cnt, duty_step, stuck, stuck_level,
                   mon_e.hi, mon_e.per, mon_e.duty, mon_e.stuck, mon_e.lvl);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] exp_duty(input int h, input int p);
    int q;
    if (p == 0) return 4'd0;
    q = (10 * h + p / 2) / p;
    if (q > 10) q = 10;
    return q[3:0];
  endfunction

  // Bench model: a rise reports the previous driven period once the block is armed.
  task automatic note_rise(input int h, input int p);
    exp_t e;
    if (tb_armed && push_en) begin
      e = '{hi: prev_h[15:0], per: prev_p[15:0], duty: exp_duty(prev_h, prev_p),
            stuck: 1'b0, lvl: 1'b0, chk_lvl: 1'b0};
      sb.push_back(e);
      push_cnt++;
    end
    tb_armed = 1;
    prev_h   = h;
    prev_p   = p;
  endtask

  task automatic drive_pwm(input int h, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      note_rise(h, p);
      for (int i = 0; i < p; i++) begin
        @(negedge clk);
        pwm_in = (i < h);
        if (i == 0) last_rise_cyc = cyc;
      end
    end
  endtask

  task automatic final_rise();
    note_rise(0, 0);
    @(negedge clk); pwm_in = 1'b1;
    @(negedge clk); pwm_in = 1'b1;
    @(negedge clk); pwm_in = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    tb_armed = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({meas_valid, high_cnt, period_cnt, duty_step, stuck, stuck_level, busy} !== 39'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, required 0",
               {meas_valid, high_cnt, period_cnt, duty_step, stuck, stuck_level, busy});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({meas_valid, stuck, busy} !== 3'b000) begin
      failures++;
      $display("FAIL post_reset_idle: got valid/stuck/busy=%b, required 000", {meas_valid, stuck, busy});
    end
  endtask

  task automatic test_50pct();
    int p0, r2;
    do_reset();
    p0 = pulse_cnt;
    drive_pwm(20, 40, 1);
    drive_pwm(20, 40, 1);
    r2 = last_rise_cyc;
    checks++;
    if ((pulse_cnt - p0) != 1) begin
      failures++;
      $display("FAIL first_pulse_count: got %0d, required 1", pulse_cnt - p0);
    end
    checks++;
    if ((last_pulse_cyc - r2) < 1 || (last_pulse_cyc - r2) > 17) begin
      failures++;
      $display("FAIL first_pulse_latency: got %0d cycles, required 1..17", last_pulse_cyc - r2);
    end
    drive_pwm(20, 40, 3);
    final_rise();
    wait_drain(40);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL 50pct_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_rounding();
    do_reset();
    drive_pwm(6, 40, 2);
    drive_pwm(5, 40, 2);
    drive_pwm(38, 40, 2);
    drive_pwm(1, 40, 1);
    drive_pwm(39, 40, 1);
    final_rise();
    wait_drain(40);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL rounding_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_loopback();
    int pushed0, consumed;
    do_reset();
    pushed0 = push_cnt;
    drive_pwm(3, 10, 12);
    final_rise();
    repeat (40) @(negedge clk);
    consumed = (push_cnt - pushed0) - sb.size();
    checks++;
    if (consumed < 1) begin
      failures++;
      $display("FAIL loopback_pulses: got %0d, required at least 1", consumed);
    end
    sb.delete();
  endtask

  task automatic test_stuck_high();
    int p0;
    exp_t e;
    do_reset();
    p0 = pulse_cnt;
    @(negedge clk);
    pwm_in = 1'b1;
    e = '{hi: 16'd0, per: 16'd0, duty: 4'd10, stuck: 1'b1, lvl: 1'b1, chk_lvl: 1'b1};
    sb.push_back(e);
    tb_armed = 0;
    repeat (TIMEOUT + 5) @(negedge clk);
    wait_drain(20);
    repeat (10) @(negedge clk);
    checks++;
    if ((pulse_cnt - p0) != 1 || sb.size() != 0) begin
      failures++;
      $display("FAIL stuck_high_pulses: got %0d pulses %0d pending, required 1 pulse 0 pending",
               pulse_cnt - p0, sb.size());
    end
    checks++;
    if ({stuck, stuck_level} !== 2'b11) begin
      failures++;
      $display("FAIL stuck_high_flags: got stuck/level=%b, required 11", {stuck, stuck_level});
    end
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    drive_pwm(10, 40, 1);
    checks++;
    if (stuck !== 1'b0) begin
      failures++;
      $display("FAIL stuck_clear: got stuck=%b, required 0", stuck);
    end
    drive_pwm(10, 40, 1);
    final_rise();
    wait_drain(40);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL resume_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_stuck_low();
    int p0;
    exp_t e;
    do_reset();
    p0 = pulse_cnt;
    e = '{hi: 16'd0, per: 16'd0, duty: 4'd0, stuck: 1'b1, lvl: 1'b0, chk_lvl: 1'b1};
    sb.push_back(e);
    wait_drain(TIMEOUT + 20);
    repeat (20) @(negedge clk);
    checks++;
    if ((pulse_cnt - p0) != 1 || sb.size() != 0) begin
      failures++;
      $display("FAIL stuck_low_pulses: got %0d pulses %0d pending, required 1 pulse 0 pending",
               pulse_cnt - p0, sb.size());
    end
    checks++;
    if ({stuck, stuck_level} !== 2'b10) begin
      failures++;
      $display("FAIL stuck_low_flags: got stuck/level=%b, required 10", {stuck, stuck_level});
    end
  endtask

  task automatic test_reset_mid_calc();
    int  p0;
    bit  seen;
    do_reset();
    push_en = 0;
    drive_pwm(20, 40, 1);
    @(negedge clk);
    pwm_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL busy_wait: got busy never high in 10 cycles, required busy=1");
    end
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({meas_valid, high_cnt, period_cnt, duty_step, stuck, stuck_level, busy} !== 39'd0) begin
      failures++;
      $display("FAIL mid_calc_reset_outputs: got %h, required 0",
               {meas_valid, high_cnt, period_cnt, duty_step, stuck, stuck_level, busy});
    end
    push_en  = 1;
    tb_armed = 0;
    p0 = pulse_cnt;
    drive_pwm(20, 40, 1);
    checks++;
    if (pulse_cnt != p0) begin
      failures++;
      $display("FAIL single_rise_no_pulse: got %0d pulses, required 0", pulse_cnt - p0);
    end
    drive_pwm(25, 40, 1);
    final_rise();
    wait_drain(40);
    checks++;
    if ((pulse_cnt - p0) != 2 || sb.size() != 0) begin
      failures++;
      $display("FAIL post_reset_pulses: got %0d pulses %0d pending, required 2 pulses 0 pending",
               pulse_cnt - p0, sb.size());
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    test_reset();
    test_50pct();
    test_rounding();
    test_loopback();
    test_stuck_high();
    test_stuck_low();
    test_reset_mid_calc();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
